// File: rtl/priority_encoder_8to3_seq.sv
// Registered 8-to-3 priority encoder with sticky pending bits, valid/ready output.
// Ports: clk, rst_n (async low), clear (sync flush), eight_input[7:0] requests,
//   out_ready, out_valid, three_output[2:0] index, pending[7:0], overflow (sticky).
module priority_encoder_8to3_seq #(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [7:0] eight_input,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] three_output,
    output logic [7:0] pending,
    output logic       overflow
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t     r_state;
    logic       r_valid;
    logic [2:0] r_code;
    logic [7:0] r_pend;
    logic       r_ovf;

    logic       w_fire;
    logic [7:0] w_gclr;
    logic [7:0] w_pend_next;
    logic       w_ovf_hit;
    logic [2:0] w_enc;

    // Scan order decides the winner: the last set bit visited is kept.
    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 8; i++)
                if (v[i]) idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        w_fire      = r_valid & out_ready;
        w_gclr      = w_fire ? (8'b1 << r_code) : 8'b0;
        w_pend_next = (r_pend & ~w_gclr) | eight_input;
        // Re-asserting the bit being granted this cycle is not an overflow.
        w_ovf_hit   = |(eight_input & r_pend & ~w_gclr);
        w_enc       = enc(w_pend_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_code  <= 3'd0;
            r_pend  <= 8'd0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_code  <= 3'd0;
            r_pend  <= 8'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            r_ovf  <= r_ovf | w_ovf_hit;
            unique case (r_state)
                S_IDLE: begin
                    if (w_pend_next != 8'd0) begin
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
                        r_code  <= w_enc;
                    end
                end
                S_HOLD: begin
                    // No preemption: the code only moves on an accepted grant.
                    if (w_fire) begin
                        if (w_pend_next != 8'd0) begin
                            r_code <= w_enc;
                        end else begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_code  <= 3'd0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_code  <= 3'd0;
                end
            endcase
        end
    end

    assign out_valid    = r_valid;
    assign three_output = r_code;
    assign pending      = r_pend;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_priority_encoder_8to3_seq.sv
// Directed testbench for priority_encoder_8to3_seq.
// Runs a high-priority and a low-priority instance on shared stimulus.
module tb_priority_encoder_8to3_seq;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [7:0] eight_input;
    logic       out_ready;

    logic       hi_valid;
    logic [2:0] hi_code;
    logic [7:0] hi_pend;
    logic       hi_ovf;
    logic       lo_valid;
    logic [2:0] lo_code;
    logic [7:0] lo_pend;
    logic       lo_ovf;

    int n_cmp;
    int n_err;

    priority_encoder_8to3_seq #(.PRIORITY_HIGH(1'b1)) u_hi (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .eight_input(eight_input), .out_ready(out_ready),
        .out_valid(hi_valid), .three_output(hi_code),
        .pending(hi_pend), .overflow(hi_ovf)
    );

    priority_encoder_8to3_seq #(.PRIORITY_HIGH(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .eight_input(eight_input), .out_ready(out_ready),
        .out_valid(lo_valid), .three_output(lo_code),
        .pending(lo_pend), .overflow(lo_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        eight_input = 8'h00;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({hi_valid, hi_code, hi_pend, hi_ovf} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_init got v=%b c=%0d p=%h o=%b want all 0",
                     hi_valid, hi_code, hi_pend, hi_ovf);
        end
        rst_n = 1'b1;
        step();
        eight_input = 8'h55;
        out_ready = 1'b0;
        step();
        eight_input = 8'h00;
        n_cmp++;
        if (hi_valid !== 1'b1 || hi_code !== 3'd6) begin
            n_err++;
            $display("FAIL reset_hold got v=%b c=%0d want v=1 c=6", hi_valid, hi_code);
        end
        n_cmp++;
        if (lo_valid !== 1'b1 || lo_code !== 3'd0) begin
            n_err++;
            $display("FAIL reset_hold_lo got v=%b c=%0d want v=1 c=0", lo_valid, lo_code);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({hi_valid, hi_code, hi_pend, hi_ovf} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_async got v=%b c=%0d p=%h o=%b want all 0",
                     hi_valid, hi_code, hi_pend, hi_ovf);
        end
        n_cmp++;
        if ({lo_valid, lo_code, lo_pend, lo_ovf} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_async_lo got v=%b c=%0d p=%h o=%b want all 0",
                     lo_valid, lo_code, lo_pend, lo_ovf);
        end
        rst_n = 1'b1;
        step();
        step();
        n_cmp++;
        if (hi_valid !== 1'b0 || hi_pend !== 8'h00) begin
            n_err++;
            $display("FAIL reset_release got v=%b p=%h want v=0 p=00", hi_valid, hi_pend);
        end
    endtask

    task automatic test_single();
        do_clear();
        eight_input = 8'h04;
        out_ready = 1'b1;
        step();
        eight_input = 8'h00;
        n_cmp++;
        if (hi_valid !== 1'b1 || hi_code !== 3'd2 || hi_pend !== 8'h04) begin
            n_err++;
            $display("FAIL single_grant got v=%b c=%0d p=%h want v=1 c=2 p=04",
                     hi_valid, hi_code, hi_pend);
        end
        step();
        n_cmp++;
        if (hi_valid !== 1'b0 || hi_pend !== 8'h00 || hi_code !== 3'd0) begin
            n_err++;
            $display("FAIL single_done got v=%b c=%0d p=%h want v=0 c=0 p=00",
                     hi_valid, hi_code, hi_pend);
        end
    endtask

    task automatic test_multi_hot();
        logic [2:0] exp_hi [3];
        logic [2:0] exp_lo [3];
        exp_hi = '{3'd7, 3'd4, 3'd1};
        exp_lo = '{3'd1, 3'd4, 3'd7};
        do_clear();
        eight_input = 8'h92;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            eight_input = 8'h00;
            n_cmp++;
            if (hi_valid !== 1'b1 || hi_code !== exp_hi[k]) begin
                n_err++;
                $display("FAIL multi_hi[%0d] got v=%b c=%0d want v=1 c=%0d",
                         k, hi_valid, hi_code, exp_hi[k]);
            end
            n_cmp++;
            if (lo_valid !== 1'b1 || lo_code !== exp_lo[k]) begin
                n_err++;
                $display("FAIL multi_lo[%0d] got v=%b c=%0d want v=1 c=%0d",
                         k, lo_valid, lo_code, exp_lo[k]);
            end
        end
        step();
        n_cmp++;
        if (hi_valid !== 1'b0 || lo_valid !== 1'b0) begin
            n_err++;
            $display("FAIL multi_end got hv=%b lv=%b want 0 0", hi_valid, lo_valid);
        end
    endtask

    task automatic test_stall();
        do_clear();
        eight_input = 8'h02;
        out_ready = 1'b0;
        step();
        eight_input = 8'h80;
        step();
        eight_input = 8'h00;
        n_cmp++;
        if (hi_valid !== 1'b1 || hi_code !== 3'd1 || hi_pend !== 8'h82) begin
            n_err++;
            $display("FAIL stall_hold got v=%b c=%0d p=%h want v=1 c=1 p=82",
                     hi_valid, hi_code, hi_pend);
        end
        step();
        n_cmp++;
        if (hi_code !== 3'd1) begin
            n_err++;
            $display("FAIL stall_stable got c=%0d want 1", hi_code);
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (hi_valid !== 1'b1 || hi_code !== 3'd7 || hi_pend !== 8'h80) begin
            n_err++;
            $display("FAIL stall_next got v=%b c=%0d p=%h want v=1 c=7 p=80",
                     hi_valid, hi_code, hi_pend);
        end
        step();
        n_cmp++;
        if (hi_valid !== 1'b0 || hi_pend !== 8'h00) begin
            n_err++;
            $display("FAIL stall_idle got v=%b p=%h want v=0 p=00", hi_valid, hi_pend);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        eight_input = 8'h08;
        out_ready = 1'b0;
        step();
        n_cmp++;
        if (hi_ovf !== 1'b0 || hi_code !== 3'd3) begin
            n_err++;
            $display("FAIL ovf_first got o=%b c=%0d want o=0 c=3", hi_ovf, hi_code);
        end
        out_ready = 1'b1;
        step();
        eight_input = 8'h00;
        n_cmp++;
        if (hi_ovf !== 1'b0 || hi_valid !== 1'b1 || hi_code !== 3'd3 ||
            hi_pend !== 8'h08) begin
            n_err++;
            $display("FAIL ovf_regrant got o=%b v=%b c=%0d p=%h want o=0 v=1 c=3 p=08",
                     hi_ovf, hi_valid, hi_code, hi_pend);
        end
        step();
        n_cmp++;
        if (hi_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_regrant_done got v=%b want 0", hi_valid);
        end
        eight_input = 8'h08;
        out_ready = 1'b0;
        step();
        step();
        eight_input = 8'h00;
        n_cmp++;
        if (hi_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set got o=%b want 1", hi_ovf);
        end
        out_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (hi_ovf !== 1'b1 || hi_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_sticky got o=%b v=%b want o=1 v=0", hi_ovf, hi_valid);
        end
    endtask

    task automatic test_clear();
        do_clear();
        eight_input = 8'hF0;
        out_ready = 1'b0;
        step();
        eight_input = 8'h10;
        step();
        n_cmp++;
        if (hi_pend !== 8'hF0 || hi_valid !== 1'b1 || hi_ovf !== 1'b1 ||
            hi_code !== 3'd7) begin
            n_err++;
            $display("FAIL clear_setup got p=%h v=%b o=%b c=%0d want p=f0 v=1 o=1 c=7",
                     hi_pend, hi_valid, hi_ovf, hi_code);
        end
        clear = 1'b1;
        eight_input = 8'h01;
        step();
        clear = 1'b0;
        eight_input = 8'h00;
        n_cmp++;
        if ({hi_valid, hi_code, hi_pend, hi_ovf} !== 13'd0) begin
            n_err++;
            $display("FAIL clear_zero got v=%b c=%0d p=%h o=%b want all 0",
                     hi_valid, hi_code, hi_pend, hi_ovf);
        end
        step();
        n_cmp++;
        if (hi_valid !== 1'b0 || hi_pend !== 8'h00) begin
            n_err++;
            $display("FAIL clear_ignored got v=%b p=%h want v=0 p=00", hi_valid, hi_pend);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        eight_input = 8'h00;
        out_ready = 1'b0;
        #12;
        test_reset();
        test_single();
        test_multi_hot();
        test_stall();
        test_overflow();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/priority_encoder_8to3_seq.md
Name: priority_encoder_8to3_seq

Overview:
- Registered 8-to-3 priority encoder. It is the inverse of the team's 3-to-8 decoder.
- Eight request lines are captured into sticky pending bits.
- The highest-priority pending index is presented as a 3-bit code with a valid/ready handshake.
- Sits between event sources (one-hot or multi-hot) and any consumer that processes one indexed event at a time.

Parameters:
- PRIORITY_HIGH, 1: 1 = highest set index wins; 0 = lowest set index wins.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of all state
- eight_input  input  8  request lines, sampled every rising edge; bit i = request for index i
- out_ready  input  1  consumer accepts three_output this cycle
- out_valid  output  1  three_output holds a valid index
- three_output  output  3  encoded index of granted request
- pending  output  8  registered pending request bits
- overflow  output  1  sticky: request arrived on an already-pending bit

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, immediate, no clock needed):
  - pending=0, out_valid=0, three_output=0, overflow=0.
  - Reset may occur mid-operation; all in-flight requests are discarded.
- clear=1 at an edge: same zero state as reset. eight_input in that cycle is ignored. clear has priority over all other events.
- fire = out_valid & out_ready.
- gclr = one-hot(three_output) when fire, else 0.
- pending_next = (pending & ~gclr) | eight_input.
  - A request re-asserted on the bit being granted in the same cycle stays pending and is reissued later.
- overflow set when, for any i: eight_input[i] & pending[i] & ~gclr[i]. Sticky until reset/clear.
- Output FSM, two states:
  - IDLE (out_valid=0, three_output=0): at each edge, if pending_next≠0 → HOLD, load three_output=enc(pending_next); else stay IDLE.
  - HOLD (out_valid=1):
    - if fire and (pending_next≠0) → stay HOLD, load enc(pending_next).
    - if fire and pending_next=0 → IDLE, three_output=0.
    - if !fire → stay HOLD; out_valid and three_output held stable even if a higher-priority request arrives (no preemption).
- enc(): PRIORITY_HIGH=1 gives the index of the highest set bit; PRIORITY_HIGH=0 gives the lowest.
- Latency:
  - Request asserted in cycle n → out_valid=1 with its index from cycle n+1, if IDLE.
  - Back-to-back grants every cycle while out_ready=1.
- The granted bit stays in pending until its fire edge. pending is therefore never 0 while out_valid=1.
- out_ready while out_valid=0 is ignored.
- Multi-cycle held eight_input bits:
  - Re-pend every cycle and set overflow while pending.
  - Sources must pulse requests for one cycle.

Test Plan:
- Reset: drive 8'h55, out_ready=0, reach HOLD; assert rst_n=0 between edges → out_valid, three_output, pending, overflow all 0 immediately. Release → stays IDLE with eight_input=0.
- Single: eight_input=8'h04 for one cycle, out_ready=1 → next cycle out_valid=1, three_output=2, pending=8'h04. Following cycle out_valid=0, pending=0.
- Multi-hot: 8'h92 one cycle, out_ready=1 → three_output=7, 4, 1 on consecutive cycles with out_valid=1, then out_valid=0. Repeat with PRIORITY_HIGH=0 → 1, 4, 7.
- Stall/no preempt:
  - 8'h02 → three_output=1; hold out_ready=0, pulse 8'h80 → three_output stays 1, pending=8'h82.
  - Raise out_ready → next cycle three_output=7, then IDLE.
- Overflow:
  - With bit 3 pending and out_ready=0, pulse 8'h08 → overflow=1 and stays 1.
  - Same-cycle re-assert of the granted bit (fire on index 3 with eight_input=8'h08) → overflow unchanged, index 3 reissued next cycle.
- Clear: pending=8'hF0, out_valid=1, overflow=1; assert clear with eight_input=8'h01 → next cycle all outputs 0, bit 0 not captured.
